mult_col_sched: RTL

MULT_COL_SCHED -- requirements
Module: mult_col_sched

---
 rtl/mult_col_sched_pkg.sv | 24 ++
 rtl/mult_col_idx.sv | 69 ++++++
 rtl/mult_col_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mult_col_sched_pkg.sv
// Shared types for the Comba column scheduler: FSM states and the per-term tag
// that travels alongside each operand pair through the 3-stage MAC pipeline.
package mult_col_sched_pkg;

  // Wide enough for column numbers up to 2*64-2.
  localparam int K_MAX_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               first;
    logic               last;
    logic [K_MAX_W-1:0] k;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/mult_col_idx.sv
// Product-scanning index generator: walks (i, k-i) in ascending k then ascending i,
// flagging the first/last term of each column and the final term of the product.
module mult_col_idx
  import mult_col_sched_pkg::*;
#(
  parameter int n_limbs = 8,
  parameter int IW      = $clog2(n_limbs),
  parameter int KW      = $clog2(2 * n_limbs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [IW-1:0]      o_i,
  output logic [IW-1:0]      o_j,
  output logic [K_MAX_W-1:0] o_k,
  output logic               o_first,
  output logic               o_last,
  output logic               o_final
);

  localparam logic [KW-1:0] K_N    = KW'(n_limbs);
  localparam logic [KW-1:0] K_NM1  = KW'(n_limbs - 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * n_limbs - 2);

  logic [IW-1:0] r_i;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_inc;
  logic [IW-1:0] w_lo;
  logic [IW-1:0] w_hi;
  logic [IW-1:0] w_lo_inc;

  // Lowest valid i for column k is max(0, k-n_limbs+1).
  function automatic logic [IW-1:0] col_lo(input logic [KW-1:0] k);
    col_lo = (k >= K_N) ? IW'(k - K_NM1) : '0;
  endfunction

  assign w_k_inc  = r_k + KW'(1);
  assign w_lo     = col_lo(r_k);
  assign w_lo_inc = col_lo(w_k_inc);
  assign w_hi     = (r_k >= K_NM1) ? IW'(K_NM1) : IW'(r_k);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_i <= '0;
      r_k <= '0;
    end else if (i_adv) begin
      if (o_last) begin
        if (o_final) begin
          r_i <= '0;
          r_k <= '0;
        end else begin
          r_i <= w_lo_inc;
          r_k <= w_k_inc;
        end
      end else begin
        r_i <= r_i + IW'(1);
      end
    end
  end

  assign o_i     = r_i;
  assign o_j     = IW'(r_k - KW'(r_i));
  assign o_k     = K_MAX_W'(r_k);
  assign o_first = (r_i == w_lo);
  assign o_last  = (r_i == w_hi);
  assign o_final = (r_k == K_LAST);

endmodule

// File: rtl/mult_col_sched.sv
// Comba column scheduler: issues limb address pairs one per cycle and steers an external MAC.
// Optional feature: define MULT_COL_SCHED_ABORT_EN to add the abort input.
module mult_col_sched
  import mult_col_sched_pkg::*;
#(
  parameter int n_limbs    = 8,
  parameter int limb_width = 27,
  parameter int o_width    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
`ifdef MULT_COL_SCHED_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(n_limbs)-1:0]    a_addr,
  output logic [$clog2(n_limbs)-1:0]    b_addr,
  input  logic [limb_width-1:0]         a_data,
  input  logic [limb_width-1:0]         b_data,
  output logic [limb_width-1:0]         mac_x,
  output logic [limb_width-1:0]         mac_y,
  output logic                          mac_clken_x,
  output logic                          mac_clken_y,
  output logic                          mac_clken_o,
  output logic                          mac_accumulate,
  output logic                          mac_aclr,
  input  logic [o_width-1:0]            mac_result,
  output logic [o_width-1:0]            col_data,
  output logic [$clog2(2*n_limbs)-1:0]  col_idx,
  output logic                          col_valid
);

  localparam int IW = $clog2(n_limbs);
  localparam int KW = $clog2(2 * n_limbs);

  if (n_limbs < 2 || n_limbs > 64) begin : g_bad_n_limbs
    $error("mult_col_sched: n_limbs must be in 2..64");
  end
  if (o_width < 2 * limb_width + $clog2(n_limbs)) begin : g_bad_o_width
    $error("mult_col_sched: o_width too narrow for a full column sum");
  end

  state_t             r_state;
  state_t             w_state_next;
  tag_t               r_tag [3];
  tag_t               w_issue_tag;
  logic               w_flush;
  logic               w_pipe_empty;
  logic [K_MAX_W-1:0] w_k;
  logic               w_first;
  logic               w_last;
  logic               w_final;
  logic               w_unused;

`ifdef MULT_COL_SCHED_ABORT_EN
  assign w_flush = abort && (r_state == ISSUE || r_state == DRAIN);
`else
  assign w_flush = 1'b0;
`endif

  mult_col_idx #(
    .n_limbs (n_limbs)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .i_clr   ((r_state != ISSUE) || w_flush),
    .i_adv   (r_state == ISSUE),
    .o_i     (a_addr),
    .o_j     (b_addr),
    .o_k     (w_k),
    .o_first (w_first),
    .o_last  (w_last),
    .o_final (w_final)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (w_flush)      w_state_next = IDLE;
        else if (w_final) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_flush)           w_state_next = IDLE;
        else if (w_pipe_empty) w_state_next = FIN;
      end
      FIN: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_issue_tag = TAG_NONE;
    if (r_state == ISSUE) begin
      w_issue_tag.valid = 1'b1;
      w_issue_tag.first = w_first;
      w_issue_tag.last  = w_last;
      w_issue_tag.k     = w_k;
    end
  end

  // Stage 0 lines up with RAM data, stage 1 with the product register,
  // stage 2 with mac_result holding the running column sum.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      for (int s = 0; s < 3; s++) r_tag[s] <= TAG_NONE;
    end else begin
      r_tag[0] <= w_issue_tag;
      r_tag[1] <= r_tag[0];
      r_tag[2] <= r_tag[1];
    end
  end

  assign w_pipe_empty   = ~(r_tag[0].valid | r_tag[1].valid | r_tag[2].valid);

  assign mac_x          = a_data;
  assign mac_y          = b_data;
  assign mac_clken_x    = r_tag[0].valid;
  assign mac_clken_y    = r_tag[0].valid;
  assign mac_clken_o    = r_tag[1].valid;
  assign mac_accumulate = r_tag[1].valid & ~r_tag[1].first;
  assign mac_aclr       = rst;

  assign col_valid      = r_tag[2].valid & r_tag[2].last;
  assign col_data       = mac_result;
  assign col_idx        = r_tag[2].k[KW-1:0];

  assign w_unused       = r_tag[2].first ^ (^r_tag[2].k);

endmodule
